// File: rtl/data_mem_unit_if.sv
// Processor-to-data-memory bus bundle: request, store data, load data, status and MMIO wires.
interface data_mem_unit_if;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dReadData;
  logic        ready;
  logic        busy;
  logic        err;
  logic [31:0] io_in;
  logic [31:0] io_out;

  modport master (
    output dAddress, dWriteData, MemRead, MemWrite, io_in,
    input  dReadData, ready, busy, err, io_out
  );

  modport slave (
    input  dAddress, dWriteData, MemRead, MemWrite, io_in,
    output dReadData, ready, busy, err, io_out
  );
endinterface

// File: rtl/data_mem_unit.sv
// Word-addressed data RAM with edge-triggered requests, programmable wait states and status pulses.
// Optional memory-mapped I/O register at IO_ADDR is enabled by defining DATA_MEM_MMIO_EN.
module data_mem_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] IO_ADDR     = 32'hFFFF0000
) (
  input logic            clk,
  input logic            rst,
  data_mem_unit_if.slave bus
);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic          rd_hist_q, wr_hist_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          io_q, io_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic [31:0]   io_out_q, io_out_d;
  logic [31:0]   mem [DEPTH];

  logic        rd_req, wr_req, any_req;
  logic        misaligned, in_range, is_io, reject, mem_we;
  logic [31:0] offset;

  // Only the rising edge of a level request starts an access.
  assign rd_req  = bus.MemRead & ~rd_hist_q;
  assign wr_req  = bus.MemWrite & ~wr_hist_q;
  assign any_req = rd_req | wr_req;

  assign offset     = bus.dAddress - BASE_ADDR;
  assign in_range   = (bus.dAddress >= BASE_ADDR) && (offset < SPAN);
  assign misaligned = (bus.dAddress[1:0] != 2'b00);

`ifdef DATA_MEM_MMIO_EN
  assign is_io = (bus.dAddress == IO_ADDR);
`else
  logic unused_io;
  assign is_io     = 1'b0;
  assign unused_io = ^{bus.io_in, IO_ADDR};
`endif

  assign reject = (rd_req & wr_req) | misaligned | ~(in_range | is_io);
  assign mem_we = (state_q == StBusy) && (cnt_q == 4'd0) && we_q && !io_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    io_d     = io_q;
    rdata_d  = rdata_q;
    io_out_d = io_out_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = 4'(WAIT_CYCLES);
            addr_d  = offset[AW+1:2];
            wdata_d = bus.dWriteData;
            we_d    = wr_req;
            io_d    = is_io;
          end
        end
      end
      StBusy: begin
        err_d = any_req;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StDone;
          ready_d = 1'b1;
          if (!we_q) begin
`ifdef DATA_MEM_MMIO_EN
            rdata_d = io_q ? bus.io_in : mem[addr_q];
`else
            rdata_d = mem[addr_q];
`endif
          end else if (io_q) begin
            io_out_d = wdata_q;
          end
        end
      end
      StDone: begin
        err_d   = any_req;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rd_hist_q <= 1'b0;
      wr_hist_q <= 1'b0;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      io_q      <= 1'b0;
      rdata_q   <= 32'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      io_out_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      rd_hist_q <= bus.MemRead;
      wr_hist_q <= bus.MemWrite;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      io_q      <= io_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      io_out_q  <= io_out_d;
    end
  end

  // RAM has no reset; a reset mid-access forces StIdle, which blocks the write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign bus.dReadData = rdata_q;
  assign bus.ready     = ready_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.io_out    = io_out_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: three instances with 0, 3 and 5 wait states share clock and reset.
module tb_data_mem_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_mem_unit_if b0 ();
  data_mem_unit_if b3 ();
  data_mem_unit_if b5 ();

  data_mem_unit #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  data_mem_unit #(.WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  data_mem_unit #(.WAIT_CYCLES(5)) u5 (.clk(clk), .rst(rst), .bus(b5));

  // Starts a request on the zero-wait instance at a falling edge.
  task automatic start0(input bit we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    b0.dAddress = a; b0.dWriteData = d; b0.MemWrite = we; b0.MemRead = !we;
  endtask

  // Full zero-wait access: request, drop, completion, back to idle.
  task automatic access0(input bit we, input logic [31:0] a, input logic [31:0] d);
    start0(we, a, d);
    @(negedge clk);
    b0.MemRead = 1'b0; b0.MemWrite = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    b0.MemRead = 0; b0.MemWrite = 0; b0.dAddress = 0; b0.dWriteData = 0; b0.io_in = 0;
    b3.MemRead = 0; b3.MemWrite = 0; b3.dAddress = 0; b3.dWriteData = 0; b3.io_in = 0;
    b5.MemRead = 0; b5.MemWrite = 0; b5.dAddress = 0; b5.dWriteData = 0; b5.io_in = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b0.busy, b0.ready, b0.err} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b want 000", {b0.busy, b0.ready, b0.err});
    end
    checks++;
    if (b0.dReadData !== 32'd0 || b0.io_out !== 32'd0) begin
      errors++; $display("FAIL reset_data got %h/%h want 0/0", b0.dReadData, b0.io_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_w0;
    start0(1'b1, 32'h10010008, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({b0.busy, b0.ready} !== 2'b10) begin
      errors++; $display("FAIL w0_write_busy got %b want 10", {b0.busy, b0.ready});
    end
    b0.MemWrite = 1'b0;
    @(negedge clk);
    checks++;
    if ({b0.busy, b0.ready, b0.err} !== 3'b110) begin
      errors++; $display("FAIL w0_write_done got %b want 110", {b0.busy, b0.ready, b0.err});
    end
    @(negedge clk);
    checks++;
    if ({b0.busy, b0.ready} !== 2'b00 || b0.dReadData !== 32'd0) begin
      errors++; $display("FAIL w0_write_idle got %b/%h want 00/0", {b0.busy, b0.ready}, b0.dReadData);
    end
    start0(1'b0, 32'h10010008, 32'h0);
    @(negedge clk);
    b0.MemRead = 1'b0;
    @(negedge clk);
    checks++;
    if (b0.ready !== 1'b1 || b0.dReadData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL w0_read got %b/%h want 1/deadbeef", b0.ready, b0.dReadData);
    end
    @(negedge clk);
    checks++;
    if (b0.ready !== 1'b0) begin
      errors++; $display("FAIL w0_ready_pulse got %b want 0", b0.ready);
    end
  endtask

  task automatic test_held_read_w3;
    int busy_n = 0, ready_n = 0, err_n = 0, ready_at = 0;
    @(negedge clk);
    b3.dAddress = 32'h10010004; b3.dWriteData = 32'hCAFEF00D; b3.MemWrite = 1'b1;
    @(negedge clk);
    b3.MemWrite = 1'b0;
    repeat (6) @(negedge clk);
    b3.MemRead = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      busy_n += int'(b3.busy);
      err_n  += int'(b3.err);
      if (b3.ready) begin
        ready_n++;
        if (ready_at == 0) ready_at = i;
      end
      if (i == 6) b3.MemRead = 1'b0;
    end
    checks++;
    if (busy_n != 5) begin errors++; $display("FAIL w3_busy_cycles got %0d want 5", busy_n); end
    checks++;
    if (ready_n != 1 || ready_at != 5) begin
      errors++; $display("FAIL w3_ready got %0d@%0d want 1@5", ready_n, ready_at);
    end
    checks++;
    if (err_n != 0 || b3.dReadData !== 32'hCAFEF00D) begin
      errors++; $display("FAIL w3_data got err%0d/%h want err0/cafef00d", err_n, b3.dReadData);
    end
  endtask

  task automatic test_reject;
    logic [31:0] addrs [3] = '{32'h10010002, 32'h1000FFFC, 32'h10010008};
    bit          wrs   [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b0.dAddress = addrs[i]; b0.MemRead = 1'b1; b0.MemWrite = wrs[i];
      @(negedge clk);
      checks++;
      if ({b0.err, b0.busy, b0.ready} !== 3'b100) begin
        errors++; $display("FAIL reject_%0d got %b want 100", i, {b0.err, b0.busy, b0.ready});
      end
      b0.MemRead = 1'b0; b0.MemWrite = 1'b0;
      @(negedge clk);
      checks++;
      if ({b0.err, b0.ready} !== 2'b00) begin
        errors++; $display("FAIL reject_pulse_%0d got %b want 00", i, {b0.err, b0.ready});
      end
    end
    checks++;
    if (b0.dReadData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reject_rdata got %h want deadbeef", b0.dReadData);
    end
  endtask

  task automatic test_busy_collision_w5;
    int ready_n = 0, err_n = 0;
    @(negedge clk);
    b5.dAddress = 32'h10010010; b5.dWriteData = 32'h11111111; b5.MemWrite = 1'b1;
    @(negedge clk);
    b5.MemWrite = 1'b0; b5.MemRead = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (b5.err !== 1'b1) begin errors++; $display("FAIL w5_collide_err got %b want 1", b5.err); end
        b5.MemRead = 1'b0;
      end
      err_n   += int'(b5.err);
      ready_n += int'(b5.ready);
    end
    checks++;
    if (ready_n != 1 || err_n != 1 || b5.busy !== 1'b0) begin
      errors++; $display("FAIL w5_collide got r%0d e%0d b%b want r1 e1 b0", ready_n, err_n, b5.busy);
    end
    checks++;
    if (b5.dReadData !== 32'd0) begin
      errors++; $display("FAIL w5_read_dropped got %h want 0", b5.dReadData);
    end
    b5.MemRead = 1'b1;
    @(negedge clk);
    b5.MemRead = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (b5.dReadData !== 32'h11111111) begin
      errors++; $display("FAIL w5_readback got %h want 11111111", b5.dReadData);
    end
    // Second write, aborted by reset while still waiting.
    b5.dWriteData = 32'h22222222; b5.MemWrite = 1'b1;
    @(negedge clk);
    b5.MemWrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({b5.busy, b5.ready, b5.err} !== 3'b000 || b5.dReadData !== 32'd0 || b5.io_out !== 32'd0) begin
      errors++; $display("FAIL w5_abort_outputs got %b/%h want 000/0", {b5.busy, b5.ready, b5.err},
                         b5.dReadData);
    end
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    b5.MemRead = 1'b1;
    @(negedge clk);
    b5.MemRead = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (b5.dReadData !== 32'h11111111) begin
      errors++; $display("FAIL w5_abort_ram got %h want 11111111", b5.dReadData);
    end
  endtask

  task automatic test_last_word;
    access0(1'b1, 32'h100103FC, 32'h12345678);
    access0(1'b0, 32'h100103FC, 32'h0);
    checks++;
    if (b0.dReadData !== 32'h12345678) begin
      errors++; $display("FAIL last_word got %h want 12345678", b0.dReadData);
    end
    access0(1'b0, 32'h10010000, 32'h0);
    checks++;
    if (b0.dReadData === 32'h12345678) begin
      errors++; $display("FAIL first_word_alias got %h want not 12345678", b0.dReadData);
    end
    start0(1'b0, 32'h10010400, 32'h0);
    @(negedge clk);
    checks++;
    if ({b0.err, b0.busy} !== 2'b10) begin
      errors++; $display("FAIL past_end got %b want 10", {b0.err, b0.busy});
    end
    b0.MemRead = 1'b0;
    repeat (2) @(negedge clk);
    access0(1'b0, 32'h100103FC, 32'h0);
  endtask

  task automatic test_mmio;
    logic exp_err;
`ifdef DATA_MEM_MMIO_EN
    exp_err = 1'b0;
`else
    exp_err = 1'b1;
`endif
    b0.io_in = 32'h77;
    start0(1'b1, 32'hFFFF0000, 32'hA5);
    @(negedge clk);
    checks++;
    if (b0.err !== exp_err) begin errors++; $display("FAIL mmio_write_err got %b want %b", b0.err, exp_err); end
    b0.MemWrite = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (b0.io_out !== (exp_err ? 32'h0 : 32'hA5)) begin
      errors++; $display("FAIL mmio_io_out got %h want %h", b0.io_out, exp_err ? 32'h0 : 32'hA5);
    end
    start0(1'b0, 32'hFFFF0000, 32'h0);
    @(negedge clk);
    checks++;
    if (b0.err !== exp_err) begin errors++; $display("FAIL mmio_read_err got %b want %b", b0.err, exp_err); end
    b0.MemRead = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (b0.dReadData !== (exp_err ? 32'h12345678 : 32'h77)) begin
      errors++; $display("FAIL mmio_read got %h want %h", b0.dReadData,
                         exp_err ? 32'h12345678 : 32'h77);
    end
  endtask

  initial begin
    test_reset();
    test_basic_w0();
    test_held_read_w3();
    test_reject();
    test_busy_collision_w5();
    test_last_word();
    test_mmio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
